// File: rtl/pipe_stage_fifo.sv
// Elastic DEPTH-entry buffer between pipeline stages, carrying payload plus exception fields.
// Optional zero-latency bypass when empty: define PIPE_STAGE_FIFO_BYPASS_EN.
module pipe_stage_fifo #(
   parameter int PAYLOAD_W = 96,
   parameter int DEPTH     = 2,
   parameter int EXC_W     = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [PAYLOAD_W-1:0]       in_payload,
   input  logic [EXC_W-1:0]           in_exc_num,
   input  logic                       in_exc_valid,
   output logic                       in_stall,
   output logic                       out_valid,
   output logic [PAYLOAD_W-1:0]       out_payload,
   output logic [EXC_W-1:0]           out_exc_num,
   output logic                       out_exc_valid,
   input  logic                       out_stall,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       exc_pending
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = PAYLOAD_W + EXC_W + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [EW-1:0]        mem [DEPTH];
   logic [PW-1:0]        wr_ptr_reg;
   logic [PW-1:0]        rd_ptr_reg;
   logic [CW-1:0]        count_reg;
   logic                 exc_pending_reg;

   logic [EW-1:0]        head;
   logic                 head_exc_valid;
   logic [EXC_W-1:0]     head_exc_num;
   logic [PAYLOAD_W-1:0] head_payload;
   logic                 stored_valid;
   logic                 push;
   logic                 pop;
   logic                 bypass;
   logic                 write_en;
   logic                 retire_en;

   assign head           = mem[rd_ptr_reg];
   assign head_exc_valid = head[EW-1];
   assign head_exc_num   = head[PAYLOAD_W +: EXC_W];
   assign head_payload   = head[PAYLOAD_W-1:0];
   assign stored_valid   = (count_reg != '0);

`ifdef PIPE_STAGE_FIFO_BYPASS_EN
   // An instruction entering an empty, unblocked buffer goes straight through and never occupies a slot.
   assign bypass = !stored_valid && in_valid && !exc_pending_reg && !out_stall;
`else
   assign bypass = 1'b0;
`endif

   // Stall comes only from registered state, so downstream backpressure never ripples upstream combinationally.
   assign in_stall  = (count_reg == FULL_COUNT) || exc_pending_reg;
   assign out_valid = stored_valid || bypass;
   assign push      = in_valid && !in_stall;
   assign pop       = out_valid && !out_stall;
   assign write_en  = push && !bypass;
   assign retire_en = pop && !bypass;

   always_comb begin
      out_payload   = '0;
      out_exc_num   = '0;
      out_exc_valid = 1'b0;
      if (bypass) begin
         out_payload   = in_payload;
         out_exc_num   = in_exc_num;
         out_exc_valid = in_exc_valid;
      end else if (stored_valid) begin
         out_payload   = head_payload;
         out_exc_num   = head_exc_num;
         out_exc_valid = head_exc_valid;
      end
   end

   assign count       = count_reg;
   assign exc_pending = exc_pending_reg;

   always_ff @(posedge clk) begin
      if (write_en) begin
         mem[wr_ptr_reg] <= {in_exc_valid, in_exc_num, in_payload};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
         exc_pending_reg <= 1'b0;
      end else if (flush) begin
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
         exc_pending_reg <= 1'b0;
      end else begin
         if (write_en) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (retire_en) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({write_en, retire_en})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         // The fence blocks pushes, so a resident exception is always the youngest entry.
         if (write_en && in_exc_valid) begin
            exc_pending_reg <= 1'b1;
         end else if (retire_en && head_exc_valid) begin
            exc_pending_reg <= 1'b0;
         end
      end
   end

   no_push_when_full : assert property (@(posedge clk) disable iff (!reset)
      !(push && (count_reg == FULL_COUNT)));

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Self-checking bench for pipe_stage_fifo (DEPTH=2): directed scenarios plus an in-order scoreboard.
module tb_pipe_stage_fifo;

   localparam int PAYLOAD_W = 96;
   localparam int DEPTH     = 2;
   localparam int EXC_W     = 6;
   localparam int EW        = PAYLOAD_W + EXC_W + 1;

   logic                    clk;
   logic                    reset;
   logic                    flush;
   logic                    in_valid;
   logic [PAYLOAD_W-1:0]    in_payload;
   logic [EXC_W-1:0]        in_exc_num;
   logic                    in_exc_valid;
   logic                    in_stall;
   logic                    out_valid;
   logic [PAYLOAD_W-1:0]    out_payload;
   logic [EXC_W-1:0]        out_exc_num;
   logic                    out_exc_valid;
   logic                    out_stall;
   logic [$clog2(DEPTH):0]  count;
   logic                    exc_pending;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] sb_q [$];

   pipe_stage_fifo #(
      .PAYLOAD_W (PAYLOAD_W),
      .DEPTH     (DEPTH),
      .EXC_W     (EXC_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_payload    (in_payload),
      .in_exc_num    (in_exc_num),
      .in_exc_valid  (in_exc_valid),
      .in_stall      (in_stall),
      .out_valid     (out_valid),
      .out_payload   (out_payload),
      .out_exc_num   (out_exc_num),
      .out_exc_valid (out_exc_valid),
      .out_stall     (out_stall),
      .count         (count),
      .exc_pending   (exc_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h at %0t", tag, obs, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: accepted entries queue up, each pop must return the oldest one.
   always @(negedge clk) begin
      if (!reset || flush) begin
         sb_q.delete();
      end else begin
         if (in_valid && !in_stall) begin
            sb_q.push_back({in_exc_valid, in_exc_num, in_payload});
         end
         if (out_valid && !out_stall) begin
            check_val("sb_pop_has_entry", 128'(sb_q.size() > 0), 128'd1);
            if (sb_q.size() > 0) begin
               check_val("sb_pop_entry", 128'({out_exc_valid, out_exc_num, out_payload}),
                         128'(sb_q.pop_front()));
            end
         end
      end
   end

   initial begin
      reset        = 1'b0;
      flush        = 1'b0;
      in_valid     = 1'b0;
      in_payload   = '0;
      in_exc_num   = '0;
      in_exc_valid = 1'b0;
      out_stall    = 1'b0;
      #2;
      check_val("rst_count", 128'(count), 128'd0);
      check_val("rst_out_valid", 128'(out_valid), 128'd0);
      check_val("rst_in_stall", 128'(in_stall), 128'd0);
      check_val("rst_exc_pending", 128'(exc_pending), 128'd0);
      check_val("rst_out_exc_valid", 128'(out_exc_valid), 128'd0);
      check_val("rst_out_payload", 128'(out_payload), 128'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Fill with downstream stalled, then drain
      out_stall = 1'b1; in_valid = 1'b1; in_payload = 96'h11;
      next_cycle();
      in_payload = 96'h22; #1;
      check_val("fill_count1", 128'(count), 128'd1);
      check_val("fill_head11", 128'(out_payload), 128'h11);
      next_cycle();
      in_valid = 1'b0; #1;
      check_val("full_count", 128'(count), 128'd2);
      check_val("full_in_stall", 128'(in_stall), 128'd1);
      out_stall = 1'b0;
      next_cycle();
      #1;
      check_val("after_pop_in_stall", 128'(in_stall), 128'd0);
      check_val("after_pop_head22", 128'(out_payload), 128'h22);
      next_cycle();
      #1;
      check_val("drained_count", 128'(count), 128'd0);
      check_val("drained_out_valid", 128'(out_valid), 128'd0);

      // Streaming with no backpressure
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_payload = PAYLOAD_W'(i); #1;
         if (i >= 2) begin
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
            check_val("stream_count", 128'(count), 128'd0);
            check_val("stream_out", 128'(out_payload), 128'(i));
`else
            check_val("stream_count", 128'(count), 128'd1);
            check_val("stream_out", 128'(out_payload), 128'(i - 1));
`endif
         end
         next_cycle();
      end
      in_valid = 1'b0;
      next_cycle();
      #1;
      check_val("stream_end_count", 128'(count), 128'd0);

      // Exception fence
      out_stall = 1'b1; in_valid = 1'b1; in_payload = 96'h33; in_exc_valid = 1'b1; in_exc_num = 6'd2;
      next_cycle();
      in_payload = 96'h44; in_exc_valid = 1'b0; in_exc_num = '0; #1;
      check_val("exc_pending_set", 128'(exc_pending), 128'd1);
      check_val("exc_in_stall", 128'(in_stall), 128'd1);
      check_val("exc_out_exc_valid", 128'(out_exc_valid), 128'd1);
      check_val("exc_out_exc_num", 128'(out_exc_num), 128'd2);
      next_cycle();
      #1;
      check_val("exc_held_count", 128'(count), 128'd1);
      check_val("exc_held_stall", 128'(in_stall), 128'd1);
      out_stall = 1'b0;
      next_cycle();
      out_stall = 1'b1; #1;
      check_val("exc_cleared", 128'(exc_pending), 128'd0);
      check_val("exc_unstalled", 128'(in_stall), 128'd0);
      check_val("exc_popped_count", 128'(count), 128'd0);
      next_cycle();
      in_valid = 1'b0; #1;
      check_val("exc_next_count", 128'(count), 128'd1);
      check_val("exc_next_payload", 128'(out_payload), 128'h44);
      check_val("exc_next_noexc", 128'(out_exc_valid), 128'd0);
      out_stall = 1'b0;
      next_cycle();
      #1;
      check_val("exc_done_count", 128'(count), 128'd0);

      // Flush while full, with a push in the same cycle
      out_stall = 1'b1; in_valid = 1'b1; in_payload = 96'h77;
      next_cycle();
      in_payload = 96'h88;
      next_cycle();
      in_payload = 96'h55; flush = 1'b1; #1;
      check_val("flush_cycle_count", 128'(count), 128'd2);
      check_val("flush_cycle_out_valid", 128'(out_valid), 128'd1);
      next_cycle();
      flush = 1'b0; in_valid = 1'b0; #1;
      check_val("flush_count", 128'(count), 128'd0);
      check_val("flush_out_valid", 128'(out_valid), 128'd0);
      check_val("flush_in_stall", 128'(in_stall), 128'd0);

      // Flush beats a simultaneous push and pop
      in_valid = 1'b1; in_payload = 96'hA1;
      next_cycle();
      in_payload = 96'h5A; out_stall = 1'b0; flush = 1'b1; #1;
      check_val("flush2_pre_count", 128'(count), 128'd1);
      next_cycle();
      flush = 1'b0; in_valid = 1'b0; #1;
      check_val("flush2_count", 128'(count), 128'd0);
      check_val("flush2_out_valid", 128'(out_valid), 128'd0);

      // Flush clears a resident exception
      out_stall = 1'b1; in_valid = 1'b1; in_payload = 96'hB2; in_exc_valid = 1'b1; in_exc_num = 6'd5;
      next_cycle();
      in_valid = 1'b0; in_exc_valid = 1'b0; in_exc_num = '0; flush = 1'b1; #1;
      check_val("flush3_pending", 128'(exc_pending), 128'd1);
      next_cycle();
      flush = 1'b0; #1;
      check_val("flush3_cleared", 128'(exc_pending), 128'd0);
      check_val("flush3_in_stall", 128'(in_stall), 128'd0);
      check_val("flush3_count", 128'(count), 128'd0);

      // Asynchronous reset mid-cycle
      in_valid = 1'b1; in_payload = 96'hC3;
      next_cycle();
      in_valid = 1'b0; #1;
      check_val("arst_pre_count", 128'(count), 128'd1);
      check_val("arst_pre_valid", 128'(out_valid), 128'd1);
      #1 reset = 1'b0;
      #1;
      check_val("arst_out_valid", 128'(out_valid), 128'd0);
      check_val("arst_count", 128'(count), 128'd0);
      check_val("arst_in_stall", 128'(in_stall), 128'd0);
      check_val("arst_out_payload", 128'(out_payload), 128'd0);
      @(posedge clk);
      #1 reset = 1'b1; out_stall = 1'b0; #1;
      check_val("arst_release_count", 128'(count), 128'd0);

      // Empty buffer, unstalled downstream
      in_valid = 1'b1; in_payload = 96'h66; #1;
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
      check_val("byp_out_valid", 128'(out_valid), 128'd1);
      check_val("byp_out_payload", 128'(out_payload), 128'h66);
      check_val("byp_count", 128'(count), 128'd0);
      next_cycle();
      in_payload = 96'h67; in_exc_valid = 1'b1; in_exc_num = 6'd3; #1;
      check_val("byp_count_after", 128'(count), 128'd0);
      check_val("byp_exc_num", 128'(out_exc_num), 128'd3);
      next_cycle();
      in_valid = 1'b0; in_exc_valid = 1'b0; in_exc_num = '0; #1;
      check_val("byp_exc_not_pending", 128'(exc_pending), 128'd0);
      check_val("byp_exc_count", 128'(count), 128'd0);
`else
      check_val("nobyp_out_valid", 128'(out_valid), 128'd0);
      next_cycle();
      in_valid = 1'b0; #1;
      check_val("nobyp_next_valid", 128'(out_valid), 128'd1);
      check_val("nobyp_next_payload", 128'(out_payload), 128'h66);
      check_val("nobyp_next_count", 128'(count), 128'd1);
      next_cycle();
      #1;
      check_val("nobyp_drained", 128'(count), 128'd0);
`endif

      repeat (3) next_cycle();
      check_val("sb_drained", 128'(sb_q.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
